// File: rtl/bemicro_cv_mem_bist.sv
// Built-in self-test master for a single-port 2**ADDR_W x 32 on-chip memory.
// Writes a deterministic pattern over the whole array, reads it back, and
// reports pass/fail, mismatch count and the first failing address. The memory
// port is shared through a mem_req/mem_gnt handshake.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, abort      run control (start sampled only when idle; abort is a level)
//   mode              0 fill, 1 check, 2/3 fill then check
//   pattern_sel, seed 0 = address pattern, 1 = LFSR seeded from seed (0 -> 1)
//   busy, done, pass  status; done is a one-cycle pulse
//   err_count         saturating mismatch count
//   first_err_addr    address of the first mismatch
//   mem_*             Avalon master towards the memory slave
module bemicro_cv_mem_bist #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic              pattern_sel,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  typedef enum logic [2:0] {StIdle, StFill, StCheck, StDrain, StDone} state_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] zext(input logic [ADDR_W-1:0] a);
    logic [31:0] r;
    r = '0;
    r[ADDR_W-1:0] = a;
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         pat_q, pat_d;       // pattern word for addr_q; drives mem_writedata
  logic [31:0]         seed_q, seed_d;
  logic                sel_q, sel_d;
  logic                fill_only_q, fill_only_d;
  logic                cmp_pend_q, cmp_pend_d;
  logic [31:0]         exp_q, exp_d;
  logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic                pass_q, pass_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cs_q, cs_d;
  logic                write_q, write_d;

  logic                issue;
  logic                last_addr;
  logic                start_acc;
  logic [31:0]         seed_fix;
  logic [ADDR_W-1:0]   addr_inc;

  assign issue     = cs_q & mem_gnt;
  assign last_addr = (addr_q == LastAddr);
  assign start_acc = (state_q == StIdle) & start & ~abort;
  assign seed_fix  = (seed == 32'd0) ? 32'd1 : seed;
  assign addr_inc  = addr_q + ADDR_W'(1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (mode == 2'd1) ? StCheck : StFill;
      StFill:  if (issue && last_addr) state_d = fill_only_q ? StDone : StCheck;
      StCheck: if (issue && last_addr) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // Output and datapath next values
  always_comb begin
    addr_d      = addr_q;
    pat_d       = pat_q;
    seed_d      = seed_q;
    sel_d       = sel_q;
    fill_only_d = fill_only_q;
    cmp_pend_d  = 1'b0;
    exp_d       = exp_q;
    cmp_addr_d  = cmp_addr_q;
    err_d       = err_q;
    first_d     = first_q;
    pass_d      = pass_q;

    if (start_acc) begin
      seed_d      = seed_fix;
      sel_d       = pattern_sel;
      fill_only_d = (mode == 2'd0);
      err_d       = '0;
      first_d     = '0;
      pass_d      = 1'b0;
      addr_d      = '0;
      pat_d       = pattern_sel ? seed_fix : 32'd0;
    end

    if (issue && !abort) begin
      addr_d = addr_inc;
      pat_d  = sel_q ? lfsr_next(pat_q) : zext(addr_inc);
      if (state_q == StCheck) begin
        cmp_pend_d = 1'b1;
        exp_d      = pat_q;
        cmp_addr_d = addr_q;
      end else if (last_addr && !fill_only_q) begin
        // Fill done: rewind address and generator for the read-back pass.
        addr_d = '0;
        pat_d  = sel_q ? seed_q : 32'd0;
      end
    end

    // Read data for the read issued on the previous edge is valid now.
    if (cmp_pend_q && !abort && (mem_readdata != exp_q)) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'd0) first_d = cmp_addr_q;
    end

    if (state_d == StDone) pass_d = fill_only_q | (err_d == 16'd0);

    busy_d  = 1'b0;
    cs_d    = 1'b0;
    write_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_d)
      StFill:  begin busy_d = 1'b1; cs_d = 1'b1; write_d = 1'b1; end
      StCheck: begin busy_d = 1'b1; cs_d = 1'b1; end
      StDrain: busy_d = 1'b1;
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      pat_q       <= '0;
      seed_q      <= 32'd1;
      sel_q       <= 1'b0;
      fill_only_q <= 1'b0;
      cmp_pend_q  <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
      err_q       <= '0;
      first_q     <= '0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_q        <= 1'b0;
      write_q     <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      pat_q       <= pat_d;
      seed_q      <= seed_d;
      sel_q       <= sel_d;
      fill_only_q <= fill_only_d;
      cmp_pend_q  <= cmp_pend_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
      err_q       <= err_d;
      first_q     <= first_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cs_q        <= cs_d;
      write_q     <= write_d;
    end
  end

  assign busy           = busy_q;
  assign mem_req        = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign mem_address    = addr_q;
  assign mem_writedata  = pat_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = write_q;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_bemicro_cv_mem_bist.sv
// Self-checking bench for bemicro_cv_mem_bist with a reduced array (ADDR_W = 10)
// so every scenario runs the complete fill/check sweep.
module tb_bemicro_cv_mem_bist;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk, reset, start, abort, pattern_sel;
  logic [1:0]    mode;
  logic [31:0]   seed;
  logic          busy, done, pass, mem_req, mem_chipselect, mem_write, mem_clken;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr, mem_address;
  logic [3:0]    mem_byteenable;
  logic [31:0]   mem_writedata, mem_readdata;
  logic          mem_gnt;

  int checks = 0;
  int errors = 0;

  bemicro_cv_mem_bist #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .pattern_sel(pattern_sel), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant driver: 0 = always granted, 1 = toggling, 2 = random 75 %.
  int gnt_mode = 0;
  initial mem_gnt = 1'b1;
  always @(negedge clk) begin
    case (gnt_mode)
      1:       mem_gnt = ~mem_gnt;
      2:       mem_gnt = ($urandom_range(0, 3) != 0);
      default: mem_gnt = 1'b1;
    endcase
  end

  // Memory model plus issue monitor. Counters restart whenever epoch changes.
  logic [31:0]   mem [DEPTH];
  logic [31:0]   rdata, rd;
  bit            fault_mask [DEPTH];
  int            epoch = 0, mon_epoch = 0;
  int            wr_cnt, rd_cnt, order_err, hold_err, done_cnt;
  bit            hold_chk = 0;
  logic          p_cs = 0, p_gnt = 0, p_we = 0;
  logic [AW-1:0] p_addr = '0;
  logic [31:0]   p_wd = '0;
  assign mem_readdata = rdata;

  always @(posedge clk) begin
    if (epoch != mon_epoch) begin
      mon_epoch = epoch;
      wr_cnt = 0; rd_cnt = 0; order_err = 0; hold_err = 0; done_cnt = 0;
    end
    if (done) done_cnt++;
    if (hold_chk && p_cs && !p_gnt)
      if ({mem_chipselect, mem_write, mem_address, mem_writedata} !== {p_cs, p_we, p_addr, p_wd})
        hold_err++;
    if (mem_chipselect && mem_gnt) begin
      if (mem_write) begin
        if (mem_address !== AW'(wr_cnt)) order_err++;
        mem[mem_address] <= mem_writedata;
        wr_cnt++;
      end else begin
        if (mem_address !== AW'(rd_cnt)) order_err++;
        rd = mem[mem_address];
        if (fault_mask[mem_address]) rd = rd ^ 32'h20;
        rdata <= rd;
        rd_cnt++;
      end
    end
    p_cs = mem_chipselect; p_gnt = mem_gnt; p_we = mem_write;
    p_addr = mem_address; p_wd = mem_writedata;
  end

  // Reference model: expected array contents and expected result of a check pass.
  logic [31:0]   model [DEPTH];
  int            exp_err;
  logic [AW-1:0] exp_first;

  task automatic build_model(input logic sel, input logic [31:0] sd);
    logic [31:0] s;
    s = (sd == 0) ? 32'd1 : sd;
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = sel ? s : 32'(i);
      s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    end
  endtask

  task automatic set_faults(input int a0, input int a1);
    for (int i = 0; i < DEPTH; i++) fault_mask[i] = (i == a0) || (i == a1);
    exp_err = 0; exp_first = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (fault_mask[i]) begin exp_err++; exp_first = AW'(i); end
  endtask

  task automatic mem_mismatches(output int n);
    n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== model[i]) n++;
  endtask

  task automatic do_start(input logic [1:0] m, input logic s, input logic [31:0] sd);
    @(negedge clk);
    epoch++;
    mode = m; pattern_sel = s; seed = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic exp_pass);
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
    end
    checks++;
    if (pass !== exp_pass) begin
      errors++; $display("FAIL %s pass: got %0b expected %0b", tag, pass, exp_pass);
    end
    checks++;
    if (err_count !== 16'(exp_err)) begin
      errors++; $display("FAIL %s err_count: got %0d expected %0d", tag, err_count, exp_err);
    end
    checks++;
    if (first_err_addr !== exp_first) begin
      errors++;
      $display("FAIL %s first_err_addr: got %0h expected %0h", tag, first_err_addr, exp_first);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s done_pulse: got done=%0b busy=%0b expected 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset;
    start = 0; abort = 0; mode = 0; pattern_sel = 0; seed = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, pass, mem_req, mem_chipselect, mem_write} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {busy, done, pass, mem_req, mem_chipselect, mem_write});
    end
    checks++;
    if (err_count !== 16'd0 || first_err_addr !== '0) begin
      errors++; $display("FAIL reset_err: got %0h/%0h expected 0/0", err_count, first_err_addr);
    end
    checks++;
    if (mem_address !== '0 || mem_writedata !== 32'd0) begin
      errors++; $display("FAIL reset_bus: got %0h/%0h expected 0/0", mem_address, mem_writedata);
    end
    checks++;
    if (mem_byteenable !== 4'hF || mem_clken !== 1'b1) begin
      errors++; $display("FAIL reset_const: got %h/%b expected f/1", mem_byteenable, mem_clken);
    end
  endtask

  task automatic test_addr_pattern;
    int lat, n;
    gnt_mode = 0; set_faults(-1, -1); build_model(1'b0, 32'd0);
    do_start(2'd2, 1'b0, $urandom);
    checks++;
    if (busy !== 1'b1 || mem_req !== 1'b1 || mem_chipselect !== 1'b1) begin
      errors++; $display("FAIL addr_busy: got %b%b%b expected 111", busy, mem_req, mem_chipselect);
    end
    wait_done(3 * DEPTH, lat);
    check_result("addr_mode2", lat, 2 * DEPTH + 1, 1'b1);
    checks++;
    if (mem[10'h25B] !== 32'h0000_025B) begin
      errors++; $display("FAIL addr_word: got %h expected 0000025b", mem[10'h25B]);
    end
    mem_mismatches(n);
    checks++;
    if (n !== 0 || order_err !== 0) begin
      errors++; $display("FAIL addr_contents: got %0d/%0d bad expected 0/0", n, order_err);
    end
  endtask

  task automatic test_fault;
    int lat;
    gnt_mode = 0; set_faults(10'h123, 10'h300);
    do_start(2'd2, 1'b0, 32'd0);
    wait_done(3 * DEPTH, lat);
    check_result("fault_mode2", lat, 2 * DEPTH + 1, 1'b0);
  endtask

  task automatic test_mode0_lfsr;
    int lat, n;
    gnt_mode = 0; set_faults(-1, -1); build_model(1'b1, 32'd0);
    do_start(2'd0, 1'b1, 32'd0);
    wait_done(2 * DEPTH, lat);
    check_result("mode0_lfsr", lat, DEPTH, 1'b1);
    checks++;
    if (mem[0] !== 32'h1 || mem[1] !== 32'h8020_0003) begin
      errors++; $display("FAIL lfsr_words: got %h %h expected 00000001 80200003", mem[0], mem[1]);
    end
    mem_mismatches(n);
    checks++;
    if (n !== 0 || rd_cnt !== 0) begin
      errors++; $display("FAIL lfsr_contents: got %0d bad %0d reads expected 0 0", n, rd_cnt);
    end
  endtask

  task automatic test_mode1_check;
    int lat;
    gnt_mode = 0; set_faults(int'($urandom_range(0, DEPTH - 1)), -1);
    do_start(2'd1, 1'b1, 32'd0);
    wait_done(2 * DEPTH, lat);
    check_result("mode1_check", lat, DEPTH + 1, 1'b0);
    checks++;
    if (wr_cnt !== 0 || rd_cnt !== DEPTH) begin
      errors++; $display("FAIL mode1_counts: got %0d/%0d expected 0/%0d", wr_cnt, rd_cnt, DEPTH);
    end
  endtask

  task automatic test_random;
    int lat, n;
    logic s;
    logic [31:0] sd;
    for (int it = 0; it < 3; it++) begin
      gnt_mode = 2;
      s = 1'($urandom_range(0, 1)); sd = $urandom;
      build_model(s, sd);
      set_faults(($urandom_range(0, 1) != 0) ? int'($urandom_range(0, DEPTH - 1)) : -1,
                 ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, DEPTH - 1)) : -1);
      do_start(2'($urandom_range(2, 3)), s, sd);
      wait_done(8 * DEPTH, lat);
      checks++;
      if (lat < 2 * DEPTH + 1) begin
        errors++; $display("FAIL random_timeout: got %0d expected >= %0d", lat, 2 * DEPTH + 1);
      end
      check_result("random", lat, lat, exp_err == 0);
      mem_mismatches(n);
      checks++;
      if (n !== 0 || order_err !== 0) begin
        errors++; $display("FAIL random_contents: got %0d/%0d bad expected 0/0", n, order_err);
      end
    end
  endtask

  task automatic test_gnt_toggle;
    int lat;
    gnt_mode = 1; hold_chk = 1; set_faults(-1, -1); build_model(1'b1, 32'h1234_5678);
    do_start(2'd2, 1'b1, 32'h1234_5678);
    wait_done(6 * DEPTH, lat);
    checks++;
    if (lat < 4 * DEPTH - 2 || lat > 4 * DEPTH + 4) begin
      errors++; $display("FAIL toggle_latency: got %0d expected about %0d", lat, 4 * DEPTH);
    end
    check_result("toggle", lat, lat, 1'b1);
    checks++;
    if (wr_cnt !== DEPTH || rd_cnt !== DEPTH || order_err !== 0 || hold_err !== 0) begin
      errors++;
      $display("FAIL toggle_access: got wr=%0d rd=%0d order=%0d hold=%0d expected %0d %0d 0 0",
               wr_cnt, rd_cnt, order_err, hold_err, DEPTH, DEPTH);
    end
    hold_chk = 0; gnt_mode = 0;
  endtask

  task automatic test_abort;
    int lat;
    gnt_mode = 0; set_faults(3, -1);
    do_start(2'd2, 1'b0, 32'd0);
    for (int n = 0; n < 3 * DEPTH; n++) begin
      @(posedge clk); #1;
      if (rd_cnt >= 500) break;
    end
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_chipselect !== 1'b0 || mem_req !== 1'b0 || err_count !== 16'd1) begin
      errors++;
      $display("FAIL abort_state: got busy=%0b cs=%0b req=%0b err=%0d expected 0 0 0 1",
               busy, mem_chipselect, mem_req, err_count);
    end
    repeat (20) @(posedge clk); #1;
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0 || err_count !== 16'd1) begin
      errors++; $display("FAIL abort_idle: got done=%0d err=%0d expected 0 1", done_cnt, err_count);
    end
    set_faults(-1, -1);
    do_start(2'd2, 1'b0, 32'd0);
    wait_done(3 * DEPTH, lat);
    check_result("after_abort", lat, 2 * DEPTH + 1, 1'b1);
  endtask

  task automatic test_reset_mid;
    int lat;
    gnt_mode = 0; set_faults(-1, -1);
    do_start(2'd2, 1'b1, 32'hCAFE_0001);
    for (int n = 0; n < 2 * DEPTH; n++) begin
      @(posedge clk); #1;
      if (wr_cnt >= 300) break;
    end
    @(negedge clk) reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_chipselect !== 1'b0 || mem_write !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%0b cs=%0b we=%0b done=%0b expected 0 0 0 0",
               busy, mem_chipselect, mem_write, done);
    end
    @(negedge clk) reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got done=%0d busy=%0b expected 0 0", done_cnt, busy);
    end
    build_model(1'b1, 32'h0BAD_F00D);
    do_start(2'd2, 1'b1, 32'h0BAD_F00D);
    wait_done(3 * DEPTH, lat);
    check_result("after_reset", lat, 2 * DEPTH + 1, 1'b1);
  endtask

  task automatic test_back_to_back_start;
    int lat;
    logic s;
    gnt_mode = 0; s = 1'($urandom_range(0, 1));
    set_faults(int'($urandom_range(0, DEPTH - 1)), -1);
    do_start(2'd3, s, $urandom);
    lat = -1;
    for (int n = 1; n <= 3 * DEPTH; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
      if (n == 100 || n == DEPTH + 100 || n == 2 * DEPTH - 5) begin
        start = 1'b1; mode = 2'd1; seed = $urandom; pattern_sel = ~s;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_result("mode3_starts", lat, 2 * DEPTH + 1, 1'b0);
    checks++;
    if (wr_cnt !== DEPTH || rd_cnt !== DEPTH || order_err !== 0) begin
      errors++;
      $display("FAIL mode3_access: got wr=%0d rd=%0d order=%0d expected %0d %0d 0",
               wr_cnt, rd_cnt, order_err, DEPTH, DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_addr_pattern();
    test_fault();
    test_mode0_lfsr();
    test_mode1_check();
    test_random();
    test_gnt_toggle();
    test_abort();
    test_reset_mid();
    test_back_to_back_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
